// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   UART_DATA_BITS  - data bits per frame (8N1)
//   UART_IDLE_LEVEL - line level while no frame is in flight
//   tx_state_e      - transmitter FSM states
//   rx_state_e      - receiver FSM states
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_CLEANUP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//   i_Clock     - system clock, rising edge
//   i_Rst_n     - asynchronous active-low reset
//   i_RX_Serial - asynchronous serial input, idles high
//   o_RX_DV     - one-cycle pulse when a byte with a valid stop bit lands
//   o_RX_Byte   - last good byte, held until the next one
// A start bit must still read low at its midpoint or it is dropped as a
// glitch; a low stop bit discards the frame without touching o_RX_Byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    // Two-flop synchronizer, reset to the idle level so reset never looks
    // like a start bit.
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q <= UART_IDLE_LEVEL;
            rx_sync_q <= UART_IDLE_LEVEL;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e          state_q;
    logic [CNT_W-1:0]   clk_cnt_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         byte_q;
    logic               dv_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (rx_sync_q == 1'b0) begin
                        state_q <= RX_START;
                    end
                end

                RX_START: begin
                    if (clk_cnt_q != HALF_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        // From here on every full bit period lands mid-bit.
                        state_q   <= (rx_sync_q == 1'b0) ? RX_DATA : RX_IDLE;
                    end
                end

                RX_DATA: begin
                    if (clk_cnt_q != BIT_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q != IDX_LAST) begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end else begin
                            bit_idx_q <= '0;
                            state_q   <= RX_STOP;
                        end
                    end
                end

                RX_STOP: begin
                    if (clk_cnt_q != BIT_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        if (rx_sync_q == UART_IDLE_LEVEL) begin
                            byte_q <= shift_q;
                            dv_q   <= 1'b1;
                        end
                        state_q <= RX_CLEANUP;
                    end
                end

                RX_CLEANUP: begin
                    state_q <= RX_IDLE;
                end

                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign o_RX_DV   = dv_q;
    assign o_RX_Byte = byte_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   i_Clock     - system clock, rising edge
//   i_Rst_n     - asynchronous active-low reset
//   i_TX_DV     - transmit request strobe, honoured only while idle
//   i_TX_Byte   - byte to send, captured with an accepted request
//   o_TX_Active - high from the start bit through the stop bit
//   o_TX_Serial - serial line, idles high
//   o_TX_Done   - one-cycle pulse as the stop bit ends
// CLKS_PER_BIT must be at least 4.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_e              state_q;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [7:0]             tx_data_q;
    logic                   serial_q;
    logic                   active_q;
    logic                   done_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_data_q <= '0;
            serial_q  <= UART_IDLE_LEVEL;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    serial_q  <= UART_IDLE_LEVEL;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (i_TX_DV) begin
                        tx_data_q <= i_TX_Byte;
                        active_q  <= 1'b1;
                        serial_q  <= 1'b0;  // start bit goes out on the next cycle
                        state_q   <= TX_START;
                    end
                end

                TX_START: begin
                    if (clk_cnt_q != BIT_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        serial_q  <= tx_data_q[0];
                        state_q   <= TX_DATA;
                    end
                end

                TX_DATA: begin
                    if (clk_cnt_q != BIT_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q != IDX_LAST) begin
                            // Shift register keeps the next bit at index 1.
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            serial_q  <= tx_data_q[1];
                            tx_data_q <= {1'b0, tx_data_q[7:1]};
                        end else begin
                            bit_idx_q <= '0;
                            serial_q  <= UART_IDLE_LEVEL;
                            state_q   <= TX_STOP;
                        end
                    end
                end

                TX_STOP: begin
                    if (clk_cnt_q != BIT_LAST) begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end else begin
                        clk_cnt_q <= '0;
                        done_q    <= 1'b1;
                        active_q  <= 1'b0;
                        state_q   <= TX_CLEANUP;
                    end
                end

                TX_CLEANUP: begin
                    state_q <= TX_IDLE;
                end

                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_TX_Active = active_q;
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: independent 8N1 transmitter and receiver on one clock/reset.
//   CLKS_PER_BIT - clock cycles per serial bit (>= 4)
//   i_Clock      - system clock, rising edge
//   i_Rst_n      - asynchronous active-low reset
//   i_TX_DV      - transmit request strobe
//   i_TX_Byte    - byte to transmit
//   o_TX_Active  - transmit frame in progress
//   o_TX_Serial  - serial output, idles high
//   o_TX_Done    - one-cycle pulse at end of a transmit frame
//   i_RX_Serial  - serial input, idles high
//   o_RX_DV      - one-cycle pulse on a received byte
//   o_RX_Byte    - last received byte
module uart_txrx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Active (o_TX_Active),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Done   (o_TX_Done)
    );

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_RX_Serial (i_RX_Serial),
        .o_RX_DV     (o_RX_DV),
        .o_RX_Byte   (o_RX_Byte)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: scoreboard bench for uart_txrx. Stimulus pushes expected
// received bytes; a monitor pops them on every o_RX_DV and also checks the
// o_TX_Done latency against the o_TX_Active rising edge.
module tb_uart_txrx;

    localparam int unsigned CLKS = 217;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_dv    = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       loop_en  = 1'b1;
    logic       drv_line = 1'b1;
    logic       rx_line;

    assign rx_line = loop_en ? (tx_active ? tx_serial : 1'b1) : drv_line;

    always #5 clk = ~clk;

    uart_txrx #(
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_TX_DV     (tx_dv),
        .i_TX_Byte   (tx_byte),
        .o_TX_Active (tx_active),
        .o_TX_Serial (tx_serial),
        .o_TX_Done   (tx_done),
        .i_RX_Serial (rx_line),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte)
    );

    int         tests       = 0;
    int         fails       = 0;
    int         cyc         = 0;
    int         rise_cyc    = 0;
    int         rx_dv_count = 0;
    int         done_count  = 0;
    logic       act_prev    = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                act_prev = 1'b0;
            end else begin
                if (tx_active && !act_prev) rise_cyc = cyc;
                act_prev = tx_active;
                if (tx_done) begin
                    done_count++;
                    check("tx_done_latency", cyc - rise_cyc, 10 * CLKS);
                    check("tx_active_at_done", int'(tx_active), 0);
                end
                if (rx_dv) begin
                    rx_dv_count++;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_dv", int'(rx_byte), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", int'(rx_byte), int'(e));
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tx(input logic [7:0] b);
        @(negedge clk);
        tx_dv   = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!tx_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_done_seen", int'(tx_done), 1);
    endtask

    task automatic send_loop(input logic [7:0] b);
        exp_q.push_back(b);
        pulse_tx(b);
        wait_done(12 * CLKS);
    endtask

    // Bit-bang one frame onto the bench-driven line; a bad stop bit is held
    // low past the receiver's mid-bit sample, then released.
    task automatic drive_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        drv_line = 1'b0;
        idle(CLKS);
        for (int i = 0; i < 8; i++) begin
            drv_line = b[i];
            idle(CLKS);
        end
        if (stop_ok) begin
            drv_line = 1'b1;
            idle(CLKS);
        end else begin
            drv_line = 1'b0;
            idle(CLKS * 3 / 4);
            drv_line = 1'b1;
        end
        idle(CLKS);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_serial"}, int'(tx_serial), 1);
        check({tag, "_tx_active"}, int'(tx_active), 0);
        check({tag, "_tx_done"},   int'(tx_done),   0);
        check({tag, "_rx_dv"},     int'(rx_dv),     0);
        check({tag, "_rx_byte"},   int'(rx_byte),   0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        idle(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        // Single loopback byte
        send_loop(8'h3F);
        idle(5);
        check("t1_tx_active_after", int'(tx_active), 0);
        check("t1_rx_count", rx_dv_count, 1);
        check("t1_rx_byte_held", int'(rx_byte), 8'h3F);

        // Back-to-back loopback, each after the previous done
        send_loop(8'h00);
        send_loop(8'hFF);
        send_loop(8'hA5);
        idle(5);
        check("t2_rx_count", rx_dv_count, 4);

        // Request while busy is ignored
        exp_q.push_back(8'h3F);
        pulse_tx(8'h3F);
        idle(500);
        pulse_tx(8'h55);
        wait_done(12 * CLKS);
        idle(3 * CLKS);
        check("t3_tx_active_after", int'(tx_active), 0);
        check("t3_rx_count", rx_dv_count, 5);
        check("t3_done_count", done_count, 5);

        // Short low glitch, then a real frame
        loop_en  = 1'b0;
        drv_line = 1'b1;
        idle(10);
        drv_line = 1'b0;
        idle(50);
        drv_line = 1'b1;
        idle(2 * CLKS);
        check("t4_glitch_no_dv", rx_dv_count, 5);
        exp_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1);
        idle(10);
        check("t4_rx_count", rx_dv_count, 6);
        check("t4_rx_byte_held", int'(rx_byte), 8'h81);

        // Framing error: no pulse, byte unchanged
        drive_frame(8'h12, 1'b0);
        idle(2 * CLKS);
        check("t5_no_dv", rx_dv_count, 6);
        check("t5_rx_byte_kept", int'(rx_byte), 8'h81);
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset mid-frame, then a clean frame
        loop_en = 1'b1;
        pulse_tx(8'hC3);
        idle(1000);
        check("t6_tx_active_mid", int'(tx_active), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        idle(5);
        rst_n = 1'b1;
        idle(5);
        check("t6_tx_active_released", int'(tx_active), 0);
        send_loop(8'h3C);
        idle(5);
        check("t6_rx_count", rx_dv_count, 7);
        check("t6_rx_byte", int'(rx_byte), 8'h3C);
        check("t6_done_count", done_count, 6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

8N1 UART transceiver: an independent transmitter (`uart_tx`) and receiver (`uart_rx`) share one clock and one reset. The block is the serial edge of the design. Parallel bytes go in through a one-cycle valid strobe and leave on a serial line. Serial frames arriving on the receive line are rebuilt into bytes and flagged by a one-cycle valid pulse. The baud rate is fixed at elaboration as a clock count per bit.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per serial bit (100 MHz / 217 ≈ 460.8 kbaud). It must be at least 4.
- `i_Clock`  in  1  system clock; everything is registered on the rising edge.
- `i_Rst_n`  in  1  reset, asynchronous, active-low.
- `i_TX_DV`  in  1  transmit request strobe.
- `i_TX_Byte`  in  8  byte to transmit; sampled when `i_TX_DV` is accepted.
- `o_TX_Active`  out  1  high while a frame (start, data, stop) is being driven.
- `o_TX_Serial`  out  1  serial output; idles high.
- `o_TX_Done`  out  1  one-cycle pulse when a frame completes.
- `i_RX_Serial`  in  1  asynchronous serial input; idles high.
- `o_RX_DV`  out  1  one-cycle pulse when a valid byte has been received.
- `o_RX_Byte`  out  8  last received byte; held until the next valid byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Transmitter FSM, states TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_CLEANUP → TX_IDLE.
  - TX_IDLE: drive `o_TX_Serial`=1. On `i_TX_DV`=1, latch `i_TX_Byte`, set `o_TX_Active`=1 and go to TX_START.
  - TX_START, TX_DATA and TX_STOP each hold their bit for exactly `CLKS_PER_BIT` cycles. A bit index 0..7 advances through TX_DATA.
  - Leaving TX_STOP: pulse `o_TX_Done` for one cycle, clear `o_TX_Active`, then spend one cycle in TX_CLEANUP.
  - `i_TX_DV` is ignored whenever the FSM is not in TX_IDLE.
- Receiver input: `i_RX_Serial` passes through a 2-flop synchronizer whose flops reset to 1.
- Receiver FSM, states RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_CLEANUP → RX_IDLE.
  - RX_IDLE: wait for a synchronized 0.
  - RX_START: count (`CLKS_PER_BIT`−1)/2 cycles, then resample. If the line is still 0, go to RX_DATA. If it is 1, treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample every `CLKS_PER_BIT` cycles, which is mid-bit, and shift into bit index 0..7.
  - RX_STOP: sample after a further `CLKS_PER_BIT` cycles. If the sample is 1, update `o_RX_Byte` and pulse `o_RX_DV`. If it is 0 (framing error), discard the byte, emit no pulse and keep `o_RX_Byte` unchanged.
  - RX_CLEANUP: one cycle, then return to RX_IDLE.
- Counter width is $clog2(`CLKS_PER_BIT`). The counter resets to 0 on every bit transition.
- Reset values: `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0, `o_RX_DV`=0, `o_RX_Byte`=0x00; both FSMs in IDLE; all counters 0.
- Reset asserted mid-frame aborts the frame immediately; nothing resumes after release.

## Timing
- Transmit start:
  - `i_TX_DV` is sampled high at edge N.
  - `o_TX_Active`=1 and `o_TX_Serial`=0 from edge N+1.
- Transmit completion:
  - `o_TX_Done` pulses 10×`CLKS_PER_BIT` cycles after edge N+1.
  - `o_TX_Active` falls in the same cycle.
- Next transmit request is accepted no earlier than 2 cycles after the `o_TX_Done` pulse (TX_CLEANUP).
- Receive latency: `o_RX_DV` pulses about 2 + (`CLKS_PER_BIT`−1)/2 + 9×`CLKS_PER_BIT` cycles after the falling start edge, i.e. mid stop bit.
  - In loopback this is before the transmitter's `o_TX_Done`.
  - `o_RX_Byte` is valid in the same cycle as `o_RX_DV`.
- TX and RX are fully independent; simultaneous activity on both is allowed.

## Structure
- Shared package `uart_pkg`: the TX and RX state enums, and constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1.
- Sub-modules `uart_tx` and `uart_rx`, each parameterised by `CLKS_PER_BIT`. `uart_txrx` only instantiates and wires them.

## Test plan
- Loopback byte, with RX line = `o_TX_Active` ? `o_TX_Serial` : 1 and `i_TX_DV` pulsed with 0x3F:
  - one `o_RX_DV` pulse with `o_RX_Byte`=0x3F;
  - one `o_TX_Done` pulse 2170 cycles after `o_TX_Active` rises;
  - `o_TX_Active` low afterwards.
- Back-to-back loopback of 0x00, 0xFF, 0xA5, each sent after the previous `o_TX_Done` → three `o_RX_DV` pulses with matching bytes, in order.
- `i_TX_DV` re-pulsed with 0x55 while a 0x3F frame is active → request ignored; only 0x3F is transmitted.
- 50-cycle low glitch on `i_RX_Serial` → no `o_RX_DV`; a following valid 0x81 frame is received correctly.
- Frame with stop bit 0 → no `o_RX_DV`; `o_RX_Byte` keeps its previous value.
- `i_Rst_n` low mid-frame → all outputs at reset values within the same cycle; the next full frame is received correctly.
